// File: rtl/data_mem_unit.sv
// Memory-side load/store responder: word RAM with byte enables and a fixed
// multi-cycle access that stalls the pipeline and returns aligned, extended loads.
module data_mem_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);
    // state | meaning
    // IDLE  | waiting for a request; checks legality combinationally
    // BUSY  | access in flight, counting down remaining stall cycles
    // DONE  | store commits / load data registered; resp_valid pulses
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [AW+1:0] l_addr;
    logic [31:0]   l_wdata;
    logic [2:0]    l_f3;
    logic          l_st;
    logic [31:0]   mem [DEPTH];

    logic          req, is_st, f3_ok, align_ok, take, stall_i, err_i;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd, word, sh, ld_val;
    logic          unused_bits;

    assign unused_bits = ^addr[31:AW+2];

    always_comb begin
        req      = req_valid & (mem_read | mem_write);
        is_st    = mem_write;
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        case (func3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~is_st;
            default:                f3_ok = 1'b0;
        endcase
        case (func3[1:0])
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        take       = 1'b0;
        stall_i    = 1'b0;
        err_i      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (f3_ok && align_ok) begin
                        take     = 1'b1;
                        stall_i  = 1'b1;
                        cnt_nx   = 4'(LATENCY - 1);
                        state_nx = (LATENCY > 1) ? BUSY : DONE;
                    end else begin
                        err_i = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_i = 1'b1;
                cnt_nx  = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gate the combinational pulses so every output reads 0 while reset is held.
    assign stall = rst_n & stall_i;
    assign err   = rst_n & err_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            l_f3    <= '0;
            l_st    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (take) begin
                l_addr  <= addr[AW+1:0];
                l_wdata <= wdata;
                l_f3    <= func3;
                l_st    <= is_st;
            end
        end
    end

    assign off = l_addr[1:0];
    assign idx = l_addr[AW+1:2];

    always_comb begin
        be = 4'hF;
        wd = l_wdata;
        case (l_f3[1:0])
            2'b00: begin
                be = 4'b0001 << off;
                wd = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{l_wdata[15:0]}};
            end
            default: begin
                be = 4'hF;
                wd = l_wdata;
            end
        endcase
    end

    always_comb begin
        word = mem[idx];
        sh   = word >> {off, 3'b000};
        case (l_f3)
            3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ld_val = {24'b0, sh[7:0]};
            3'b101:  ld_val = {16'b0, sh[15:0]};
            default: ld_val = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == DONE && l_st) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (state == DONE && !l_st) rdata <= ld_val;
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: directed spec scenarios plus random
// loads/stores checked against a byte-array reference model.
module tb_data_mem_unit;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        stall, resp_valid, err;
    logic [31:0] rdata;

    data_mem_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .func3(func3), .addr(addr), .wdata(wdata),
        .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 1 = response, 2 = error
        int          cyc;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mm [DEPTH];
    logic [31:0] rdata_m = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] pend_val;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit f_ok;
        bit a_ok;
        if (st) f_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    f_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (f3[1:0] == 2'd1)      a_ok = (a % 2 == 0);
        else if (f3[1:0] == 2'd2) a_ok = (a % 4 == 0);
        else                      a_ok = 1'b1;
        return f_ok && a_ok;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int w = int'((a / 4) % DEPTH);
        int b0 = int'(a % 4);
        int n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) mm[w][8*(b0+k) +: 8] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          w = int'((a / 4) % DEPTH);
        logic [31:0] v = mm[w] >> (8 * (a % 4));
        logic [7:0]  b = v[7:0];
        logic [15:0] h = v[15:0];
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return v;
        endcase
    endfunction

    // Monitor: pops an expectation whenever the DUT pulses resp_valid or err,
    // then checks the registered rdata one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            chk("rdata", rdata, pend_val);
            pend = 1'b0;
        end
        if (rst_n && (resp_valid || err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got resp_valid=%0b err=%0b expected none", resp_valid, err);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'b0, err, resp_valid}, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
                pend     = 1'b1;
                pend_val = e.rd;
            end
        end
    end

    task automatic clear_inputs();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        func3     = 3'd0;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        bit   ok = legal(wr, f3, a);
        int   stalls = 0;
        bit   seen = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        func3 = f3; addr = a; wdata = d;
        if (!ok) begin
            e.kind = 2; e.cyc = cyc;
        end else begin
            if (wr) model_store(f3, a, d);
            else    rdata_m = model_load(f3, a);
            e.kind = 1; e.cyc = cyc + LAT;
        end
        e.rd = rdata_m;
        sb.push_back(e);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (resp_valid || err) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no response expected one within 40 cycles");
        end
        chk("stall_cycles", stalls, ok ? LAT : 0);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        bit          rd, wr;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < 16; w++) access(0, 1, 3'd2, w * 4, $urandom);

        access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        access(1, 0, 3'd2, 32'h10, 32'h0);
        chk("lw_deadbeef", rdata_m, 32'hDEADBEEF);
        access(0, 1, 3'd0, 32'h13, 32'h80);
        access(1, 0, 3'd0, 32'h13, 32'h0);
        chk("lb_80", rdata_m, 32'hFFFFFF80);
        access(1, 0, 3'd4, 32'h13, 32'h0);
        chk("lbu_80", rdata_m, 32'h00000080);
        access(1, 0, 3'd2, 32'h10, 32'h0);
        chk("lw_80adbeef", rdata_m, 32'h80ADBEEF);
        access(1, 0, 3'd1, 32'h13, 32'h0);
        access(1, 0, 3'd2, 32'h11, 32'h0);
        access(0, 1, 3'd1, 32'h11, 32'h5555);
        access(1, 0, 3'd2, 32'h10, 32'h0);
        chk("no_change_after_err", rdata_m, 32'h80ADBEEF);
        access(0, 1, 3'd2, 32'h1000, 32'h1234);
        access(1, 0, 3'd2, 32'h0, 32'h0);
        chk("wrap_lw", rdata_m, 32'h00001234);

        // Reset during BUSY of a store must abandon it.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_write = 1'b1; func3 = 3'd2; addr = 32'h20; wdata = 32'h55;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, stall}, 0);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 0);
        chk("midrst_err", {31'b0, err}, 0);
        chk("midrst_rdata", rdata, 0);
        rdata_m = 32'h0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 3'd2, 32'h20, 32'h0);

        access(1, 1, 3'd2, 32'h8, 32'hA5A5A5A5);
        access(1, 0, 3'd2, 32'h8, 32'h0);
        chk("both_is_store", rdata_m, 32'hA5A5A5A5);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 1) == 1) begin
                    req_valid = 1'b1;
                end else begin
                    mem_read  = 1'($urandom_range(0, 1));
                    mem_write = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                chk("idle_stall", {31'b0, stall}, 0);
                @(posedge clk); #1;
                clear_inputs();
            end else begin
                a  = $urandom & 32'hFFFF_F03F;
                f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) f3 = 3'd2;
                rd = 1'($urandom_range(0, 1));
                wr = ~rd | 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) a = a & 32'hFFFF_FFFC;
                access(rd, wr, f3, a, $urandom);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
